ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Keyboard front end for the calculator. Receives the PS/2 device-to-host serial stream and decodes Set-2 scan codes into ASCII.
- Produces the key_ascii / key_pressed event interface consumed by the calculator display/edit logic.
- Emits one key_pressed pulse per make code of a calculator-relevant key.
- Break codes, unmapped keys and bad frames produce no key event.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized ps2_clk samples required before the filtered clock changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge, in a non-IDLE frame state, before the frame is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_ascii  out  8  ASCII code of the last accepted key; held between events.
- key_pressed  out  1  single-cycle strobe; key_ascii is valid in the same cycle.
- scan_code  out  8  last good received byte, raw; held.
- frame_error  out  1  single-cycle strobe on parity, stop-bit or timeout error.

Behaviour:
- One clock domain only. reset and ps2_* are never sampled combinationally.
- Reset values:
  - key_ascii=0x00, key_pressed=0, scan_code=0x00, frame_error=0.
  - Frame FSM in IDLE; break, ext and shift flags cleared; filter counter 0; filtered clock 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock toggles only after FILTER_LEN consecutive samples that differ from its current value.
  - A sample strobe fires on a filtered 1->0 transition; data is taken from the synchronized ps2_data in that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0 (start bit) -> DATA, bit count 0. Strobe with data=1 is ignored.
  - DATA: shift in LSB first. After the 8th strobe -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on strobe -> IDLE. The frame is good when data=1 and the 8 data bits plus parity have an odd number of ones.
  - Good frame: byte_valid pulses in the cycle after the stop strobe, and scan_code updates in that cycle.
  - Bad frame: frame_error pulses in the cycle after the stop strobe; the byte is discarded and decode flags are unchanged.
  - Watchdog counts while not IDLE and clears on each strobe. On reaching TIMEOUT_CYCLES -> IDLE, frame_error pulses, and the partial byte is discarded.
- Decode, acting on byte_valid:
  - 0xE0: set ext. 0xF0: set break. No event.
  - Any other byte consumes both flags, which clear in the same cycle.
  - Shift tracking: non-ext 0x12 or 0x59 sets shift on make and clears it on break. Ext 0x12 is ignored.
  - Break of any key: no event.
  - Make of a mapped key: key_pressed=1 and key_ascii updated in the cycle after byte_valid. Total latency is 2 clk after the stop-bit strobe.
  - Typematic repeats (repeated makes) each produce an event.
- Map, non-ext:
  - Digits: 0x45'0' 0x16'1' 0x1E'2' 0x26'3' 0x25'4' 0x2E'5' 0x36'6' 0x3D'7' 0x3E'8' 0x46'9'.
  - Shift+0x3E -> '*'; shift+other digit -> no event.
  - 0x4E'-'. 0x4A'/'.
  - 0x55: '=' unshifted, '+' shifted.
  - Keypad: 0x70..: 0x70'0' 0x69'1' 0x72'2' 0x7A'3' 0x6B'4' 0x73'5' 0x74'6' 0x6C'7' 0x75'8' 0x7D'9' 0x79'+' 0x7B'-' 0x7C'*'. Keypad keys ignore shift.
  - 0x5A -> 10 (Enter). 0x66 -> 8 (Backspace). 0x76 -> 27 (Esc).
- Map, ext: E0 4A -> '/'. E0 5A -> 10. All other ext codes -> no event.
- Simultaneous events: a watchdog expiry and a strobe in the same cycle resolve in favour of the strobe, which clears the watchdog.
- Reset asserted mid-frame aborts the frame; no strobe is emitted.

Decomposition:
- Package calc_kbd_pkg:
  - Frame FSM enum.
  - Scan-code constants: SC_EXT=0xE0, SC_BREAK=0xF0, SC_LSHIFT, SC_RSHIFT, SC_ENTER, SC_BKSP, SC_ESC.
  - ASCII constants: ASCII_BS=8, ASCII_LF=10, ASCII_ESC=27.
- Sub-module ps2_rx_frame: synchronizers, filter, frame FSM and watchdog. Outputs byte, byte_valid, frame_error.
- The top level holds the flags and the mapping function.

Test Plan:
- Bench timing for all scenarios: FILTER_LEN=8, PS/2 half-period 100 clk.
- Frame 0x16 with parity 0, stop 1 -> scan_code=0x16, one key_pressed with key_ascii=0x31 exactly 2 clk after the stop strobe.
- Sequence 0x16, F0, 16 -> exactly one event ('1'). The break produces no pulse, and the flags are clear afterwards.
- 12, 55, F0 55, F0 12, 55 -> events '+' then '='.
- E0 4A -> '/'; 4A -> '/'; E0 5A -> 10. Then 76 -> 27 and 66 -> 8. Then 0x1C ('A') -> no event.
- 0x45 sent with parity forced wrong -> frame_error pulse, no event, scan_code unchanged. The next good 0x45 -> '0'.
- Start bit plus 3 data bits, then ps2_clk held high -> frame_error exactly TIMEOUT_CYCLES after the last strobe. The next full frame 0x3D -> '7'.
- 8-clk ps2_clk glitches (4 low) -> no strobe.
- reset pulsed mid-frame -> all outputs return to reset values, and the next frame decodes normally.

Source files
------------

// File: rtl/calc_kbd_pkg.sv
// Shared types and constants for the calculator keyboard front end.
// Holds the PS/2 frame FSM states, the Set-2 scan codes and ASCII controls.
package calc_kbd_pkg;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [7:0] ASCII_BS  = 8'd8;
    localparam logic [7:0] ASCII_LF  = 8'd10;
    localparam logic [7:0] ASCII_ESC = 8'd27;

    typedef struct packed {
        logic       valid;
        logic [7:0] ascii;
    } key_map_t;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronizers, clock glitch filter,
// 11-bit frame FSM and inactivity watchdog.
module ps2_rx_frame
    import calc_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_filt;
    logic [FW-1:0] r_fcnt;
    logic          w_strobe;

    frame_state_t  r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_sreg;
    logic          r_par;
    logic [WW-1:0] r_wdog;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // High in the cycle whose clock edge flips the filtered clock 1->0.
    assign w_strobe = r_filt && !r_clk_s2 && (r_fcnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= FR_IDLE;
            r_bitcnt <= '0;
            r_sreg   <= '0;
            r_par    <= 1'b0;
            r_wdog   <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_strobe) begin
                // Watchdog counts from the strobe cycle itself, so expiry lands
                // exactly TIMEOUT_CYCLES cycles after the last strobe.
                r_wdog <= WW'(1);
                case (r_state)
                    FR_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= FR_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_wdog <= '0;
                        end
                    end
                    FR_DATA: begin
                        r_sreg   <= {r_dat_s2, r_sreg[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= FR_PARITY;
                        end
                    end
                    FR_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= FR_STOP;
                    end
                    FR_STOP: begin
                        r_state <= FR_IDLE;
                        r_wdog  <= '0;
                        if (r_dat_s2 && odd_parity_ok(r_sreg, r_par)) begin
                            r_byte  <= r_sreg;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= FR_IDLE;
                endcase
            end else if (r_state != FR_IDLE) begin
                if (r_wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= FR_IDLE;
                    r_wdog  <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

    assign o_byte        = r_byte;
    assign o_byte_valid  = r_valid;
    assign o_frame_error = r_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// Calculator keyboard front end: PS/2 receiver plus Set-2 make/break/shift
// tracking and scan-code to ASCII mapping for calculator keys.
module ps2_key_decoder
    import calc_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_ascii,
    output logic       key_pressed,
    output logic [7:0] scan_code,
    output logic       frame_error
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_error;
    key_map_t   w_map;

    logic       r_ext;
    logic       r_brk;
    logic       r_shift;
    logic [7:0] r_key_ascii;
    logic       r_key_pressed;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .o_byte        (w_byte),
        .o_byte_valid  (w_byte_valid),
        .o_frame_error (w_frame_error)
    );

    function automatic key_map_t map_key(input logic ext, input logic shift,
                                         input logic [7:0] sc);
        key_map_t m;
        logic     digit;
        m.valid = 1'b1;
        m.ascii = 8'h00;
        digit   = 1'b0;
        if (ext) begin
            case (sc)
                8'h4A:    m.ascii = 8'h2F;
                SC_ENTER: m.ascii = ASCII_LF;
                default:  m.valid = 1'b0;
            endcase
        end else begin
            case (sc)
                8'h45: begin m.ascii = 8'h30; digit = 1'b1; end
                8'h16: begin m.ascii = 8'h31; digit = 1'b1; end
                8'h1E: begin m.ascii = 8'h32; digit = 1'b1; end
                8'h26: begin m.ascii = 8'h33; digit = 1'b1; end
                8'h25: begin m.ascii = 8'h34; digit = 1'b1; end
                8'h2E: begin m.ascii = 8'h35; digit = 1'b1; end
                8'h36: begin m.ascii = 8'h36; digit = 1'b1; end
                8'h3D: begin m.ascii = 8'h37; digit = 1'b1; end
                8'h3E: begin m.ascii = 8'h38; digit = 1'b1; end
                8'h46: begin m.ascii = 8'h39; digit = 1'b1; end
                8'h4E:    m.ascii = 8'h2D;
                8'h4A:    m.ascii = 8'h2F;
                8'h55:    m.ascii = shift ? 8'h2B : 8'h3D;
                8'h70:    m.ascii = 8'h30;
                8'h69:    m.ascii = 8'h31;
                8'h72:    m.ascii = 8'h32;
                8'h7A:    m.ascii = 8'h33;
                8'h6B:    m.ascii = 8'h34;
                8'h73:    m.ascii = 8'h35;
                8'h74:    m.ascii = 8'h36;
                8'h6C:    m.ascii = 8'h37;
                8'h75:    m.ascii = 8'h38;
                8'h7D:    m.ascii = 8'h39;
                8'h79:    m.ascii = 8'h2B;
                8'h7B:    m.ascii = 8'h2D;
                8'h7C:    m.ascii = 8'h2A;
                SC_ENTER: m.ascii = ASCII_LF;
                SC_BKSP:  m.ascii = ASCII_BS;
                SC_ESC:   m.ascii = ASCII_ESC;
                default:  m.valid = 1'b0;
            endcase
            // Shifted top-row digits only yield '*' (shift+8).
            if (digit && shift) begin
                if (sc == 8'h3E) begin
                    m.ascii = 8'h2A;
                end else begin
                    m.valid = 1'b0;
                end
            end
        end
        return m;
    endfunction

    always_comb begin
        w_map = map_key(r_ext, r_shift, w_byte);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_shift       <= 1'b0;
            r_key_ascii   <= '0;
            r_key_pressed <= 1'b0;
        end else begin
            r_key_pressed <= 1'b0;
            if (w_byte_valid) begin
                if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (!r_ext && (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT)) begin
                        r_shift <= !r_brk;
                    end else if (!r_brk && w_map.valid) begin
                        r_key_pressed <= 1'b1;
                        r_key_ascii   <= w_map.ascii;
                    end
                end
            end
        end
    end

    assign key_ascii   = r_key_ascii;
    assign key_pressed = r_key_pressed;
    assign scan_code   = w_byte;
    assign frame_error = w_frame_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand-written
// timeout/glitch/reset sequences and random frames against a key-rule model.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 100;
    localparam int CLK_P      = 10;
    // Cycles from a ps2_clk fall (driven on a negedge) to the sample strobe:
    // two synchronizer flops, then FILTER_LEN-1 counts before the toggle.
    localparam int STROBE_N   = 2 + FILTER_LEN - 1;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_ascii;
    logic       key_pressed;
    logic [7:0] scan_code;
    logic       frame_error;

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_ascii   (key_ascii),
        .key_pressed (key_pressed),
        .scan_code   (scan_code),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    time        ev_t[$];
    logic [7:0] ev_a[$];
    time        err_t[$];

    always @(negedge clk) begin
        if (key_pressed) begin
            ev_t.push_back($time);
            ev_a.push_back(key_ascii);
        end
        if (frame_error) err_t.push_back($time);
    end

    // Reference model state: decode flags and key tables.
    logic       m_ext = 1'b0, m_brk = 1'b0, m_shift = 1'b0;
    logic [7:0] exp_scan = 8'h00;
    logic [7:0] dig_map   [int];
    logic [7:0] plain_map [int];
    logic [7:0] ext_map   [int];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic model_byte(input logic [7:0] b, output logic ev, output logic [7:0] a);
        logic e, k;
        ev = 1'b0;
        a  = 8'h00;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            e = m_ext;
            k = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
            if (!e && (b == 8'h12 || b == 8'h59)) m_shift = !k;
            else if (!k) begin
                if (e) begin
                    if (ext_map.exists(int'(b))) begin ev = 1'b1; a = ext_map[int'(b)]; end
                end else if (dig_map.exists(int'(b))) begin
                    if (!m_shift) begin ev = 1'b1; a = dig_map[int'(b)]; end
                    else if (dig_map[int'(b)] == 8'h38) begin ev = 1'b1; a = 8'h2A; end
                end else if (b == 8'h55) begin
                    ev = 1'b1;
                    a  = m_shift ? 8'h2B : 8'h3D;
                end else if (plain_map.exists(int'(b))) begin
                    ev = 1'b1;
                    a  = plain_map[int'(b)];
                end
            end
        end
    endtask

    task automatic ps2_bit(input logic b, output time t_fall);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        t_fall  = $time;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad, output time t_stop);
        time t;
        ps2_bit(1'b0, t);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], t);
        ps2_bit(~(^b) ^ bad, t);
        ps2_bit(1'b1, t_stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_obs();
        ev_t.delete();
        ev_a.delete();
        err_t.delete();
    endtask

    task automatic check_frame(input string tag, input logic ev, input logic [7:0] a,
                               input logic err, input time t_stop);
        check({tag, " key_count"}, longint'(ev_t.size()), longint'(ev));
        if (ev && ev_t.size() > 0) begin
            check({tag, " key_latency"}, longint'(ev_t[0] - t_stop),
                  longint'((STROBE_N + 2) * CLK_P));
            check({tag, " key_ascii"}, longint'(ev_a[0]), longint'(a));
        end
        check({tag, " err_count"}, longint'(err_t.size()), longint'(err));
        if (err && err_t.size() > 0)
            check({tag, " err_latency"}, longint'(err_t[0] - t_stop),
                  longint'((STROBE_N + 1) * CLK_P));
        check({tag, " scan_code"}, longint'(scan_code), longint'(exp_scan));
        clear_obs();
    endtask

    typedef struct {
        logic [7:0] sc;
        logic       bad;
        logic       ev;
        logic [7:0] ascii;
    } vec_t;

    vec_t       tbl[21];
    logic [7:0] pool[17];

    initial begin
        time        t;
        logic       mev;
        logic [7:0] ma;
        logic [7:0] b;
        logic       bad;

        dig_map = '{32'h45:8'h30, 32'h16:8'h31, 32'h1E:8'h32, 32'h26:8'h33, 32'h25:8'h34,
                    32'h2E:8'h35, 32'h36:8'h36, 32'h3D:8'h37, 32'h3E:8'h38, 32'h46:8'h39};
        plain_map = '{32'h4E:8'h2D, 32'h4A:8'h2F, 32'h5A:8'h0A, 32'h66:8'h08, 32'h76:8'h1B,
                      32'h70:8'h30, 32'h69:8'h31, 32'h72:8'h32, 32'h7A:8'h33, 32'h6B:8'h34,
                      32'h73:8'h35, 32'h74:8'h36, 32'h6C:8'h37, 32'h75:8'h38, 32'h7D:8'h39,
                      32'h79:8'h2B, 32'h7B:8'h2D, 32'h7C:8'h2A};
        ext_map = '{32'h4A:8'h2F, 32'h5A:8'h0A};

        tbl = '{
            '{8'h16, 1'b0, 1'b1, 8'h31},
            '{8'h16, 1'b0, 1'b1, 8'h31}, '{8'hF0, 1'b0, 1'b0, 8'h00}, '{8'h16, 1'b0, 1'b0, 8'h00},
            '{8'h12, 1'b0, 1'b0, 8'h00}, '{8'h55, 1'b0, 1'b1, 8'h2B}, '{8'hF0, 1'b0, 1'b0, 8'h00},
            '{8'h55, 1'b0, 1'b0, 8'h00}, '{8'hF0, 1'b0, 1'b0, 8'h00}, '{8'h12, 1'b0, 1'b0, 8'h00},
            '{8'h55, 1'b0, 1'b1, 8'h3D},
            '{8'hE0, 1'b0, 1'b0, 8'h00}, '{8'h4A, 1'b0, 1'b1, 8'h2F}, '{8'h4A, 1'b0, 1'b1, 8'h2F},
            '{8'hE0, 1'b0, 1'b0, 8'h00}, '{8'h5A, 1'b0, 1'b1, 8'h0A}, '{8'h76, 1'b0, 1'b1, 8'h1B},
            '{8'h66, 1'b0, 1'b1, 8'h08}, '{8'h1C, 1'b0, 1'b0, 8'h00},
            '{8'h45, 1'b1, 1'b0, 8'h00}, '{8'h45, 1'b0, 1'b1, 8'h30}
        };
        pool = '{8'h16, 8'h1E, 8'h26, 8'h3E, 8'h45, 8'h55, 8'h12, 8'h59, 8'hF0,
                 8'hE0, 8'h4A, 8'h5A, 8'h7C, 8'h79, 8'h1C, 8'h70, 8'h66};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset key_ascii", longint'(key_ascii), 0);
        check("reset key_pressed", longint'(key_pressed), 0);
        check("reset scan_code", longint'(scan_code), 0);
        check("reset frame_error", longint'(frame_error), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        clear_obs();

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            send_frame(tbl[i].sc, tbl[i].bad, t);
            if (!tbl[i].bad) begin
                model_byte(tbl[i].sc, mev, ma);
                exp_scan = tbl[i].sc;
            end
            check_frame($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ascii, tbl[i].bad, t);
        end

        // Partial frame: start + 3 data bits, then the clock stays high
        ps2_bit(1'b0, t);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, t);
        repeat (TIMEOUT + 200) @(negedge clk);
        check("timeout err_count", longint'(err_t.size()), 1);
        if (err_t.size() > 0)
            check("timeout err_latency", longint'(err_t[0] - t),
                  longint'((STROBE_N + TIMEOUT) * CLK_P));
        check("timeout key_count", longint'(ev_t.size()), 0);
        check("timeout scan_code", longint'(scan_code), longint'(exp_scan));
        clear_obs();
        send_frame(8'h3D, 1'b0, t);
        model_byte(8'h3D, mev, ma);
        exp_scan = 8'h3D;
        check_frame("after_timeout", 1'b1, 8'h37, 1'b0, t);

        // Short clock glitches with data low must not start a frame
        ps2_data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        check("glitch err_count", longint'(err_t.size()), 0);
        check("glitch key_count", longint'(ev_t.size()), 0);
        clear_obs();
        send_frame(8'h26, 1'b0, t);
        model_byte(8'h26, mev, ma);
        exp_scan = 8'h26;
        check_frame("after_glitch", 1'b1, 8'h33, 1'b0, t);

        // Shift held, then reset mid-frame clears everything
        send_frame(8'h12, 1'b0, t);
        model_byte(8'h12, mev, ma);
        exp_scan = 8'h12;
        check_frame("shift_make", 1'b0, 8'h00, 1'b0, t);
        ps2_bit(1'b0, t);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), t);
        reset = 1'b1;
        @(negedge clk);
        check("midreset key_ascii", longint'(key_ascii), 0);
        check("midreset key_pressed", longint'(key_pressed), 0);
        check("midreset scan_code", longint'(scan_code), 0);
        check("midreset frame_error", longint'(frame_error), 0);
        @(negedge clk);
        reset = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0;
        exp_scan = 8'h00;
        clear_obs();
        repeat (50) @(negedge clk);
        send_frame(8'h3E, 1'b0, t);
        model_byte(8'h3E, mev, ma);
        exp_scan = 8'h3E;
        check_frame("after_reset", 1'b1, 8'h38, 1'b0, t);

        // Random frames against the model
        for (int i = 0; i < 5; i++) begin
            b   = pool[$urandom_range(0, 16)];
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad, t);
            mev = 1'b0;
            ma  = 8'h00;
            if (!bad) begin
                model_byte(b, mev, ma);
                exp_scan = b;
            end
            check_frame($sformatf("rnd%0d_%02h", i, b), mev, ma, bad, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
